// File: rtl/lat_track_pkg.sv
// lat_track_pkg: shared defaults, types and saturating stat increment for the latency tag tracker.
package lat_track_pkg;
  localparam int COUNTER_WIDTH_DEF = 64;
  localparam int TAG_WIDTH_DEF = 6;
  typedef logic [TAG_WIDTH_DEF-1:0] tag_t;
  typedef struct packed {
    logic valid;
    logic [COUNTER_WIDTH_DEF-1:0] ts;
  } entry_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/lat_track_sweeper.sv
// lat_track_sweeper: round-robin pointer that requests expiry of aged entries (used with LAT_TRACK_TIMEOUT_EN).
module lat_track_sweeper #(
  parameter int COUNTER_WIDTH = 64,
  parameter int TAG_WIDTH = 6,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_i,
  input  logic                     block_i,
  input  logic                     valid_i,
  input  logic [COUNTER_WIDTH-1:0] ts_i,
  input  logic [COUNTER_WIDTH-1:0] now_i,
  output logic [TAG_WIDTH-1:0]     ptr_o,
  output logic                     clr_o
);
  logic [TAG_WIDTH-1:0] ptr_q;
  logic [COUNTER_WIDTH-1:0] age;
  assign age = now_i - ts_i;
  assign ptr_o = ptr_q;
  assign clr_o = step_i && valid_i && !block_i && age >= COUNTER_WIDTH'(TIMEOUT_CYCLES);
  always_ff @(posedge clk)
    if (rst) ptr_q <= '0;
    else if (step_i) ptr_q <= ptr_q + 1'b1;
endmodule

// File: rtl/latency_tag_tracker.sv
// latency_tag_tracker: per-tag start timestamp table emitting {start,end} latency samples.
module latency_tag_tracker import lat_track_pkg::*; #(
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] timestamp,
  input  logic                     cfg_enable,
  input  logic                     cfg_clear,
  input  logic                     start_valid,
  input  logic [TAG_WIDTH-1:0]     start_tag,
  input  logic                     end_valid,
  input  logic [TAG_WIDTH-1:0]     end_tag,
  output logic [COUNTER_WIDTH-1:0] latency_start,
  output logic [COUNTER_WIDTH-1:0] latency_end,
  output logic                     latency_valid,
  output logic [TAG_WIDTH:0]       pending_count,
  output logic [31:0]              stat_orphan_end,
  output logic [31:0]              stat_dup_start,
  output logic [31:0]              stat_timeout
);
  localparam int DEPTH = 1 << TAG_WIDTH;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [COUNTER_WIDTH-1:0] ts_q [DEPTH];
  logic [COUNTER_WIDTH-1:0] lat_start_q, lat_end_q;
  logic lat_valid_q;
  logic [TAG_WIDTH:0] pending_q, pending_d;
  logic [31:0] orphan_q, dup_q;
  logic st, ed, end_hit, orphan, dup, sw_clr;
  logic [TAG_WIDTH-1:0] sw_ptr;
  assign st = start_valid && cfg_enable && !cfg_clear;
  assign ed = end_valid && cfg_enable && !cfg_clear;
  assign end_hit = ed && valid_q[end_tag];
  assign orphan = ed && !valid_q[end_tag];
  assign dup = st && valid_q[start_tag] && !(ed && end_tag == start_tag);
`ifdef LAT_TRACK_TIMEOUT_EN
  logic [31:0] timeout_q;
  lat_track_sweeper #(
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .TAG_WIDTH(TAG_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_sweeper (
    .clk(clk),
    .rst(rst),
    .step_i(cfg_enable && !cfg_clear),
    .block_i((start_valid && start_tag == sw_ptr) || (end_valid && end_tag == sw_ptr)),
    .valid_i(valid_q[sw_ptr]),
    .ts_i(ts_q[sw_ptr]),
    .now_i(timestamp),
    .ptr_o(sw_ptr),
    .clr_o(sw_clr)
  );
  always_ff @(posedge clk)
    if (rst || cfg_clear) timeout_q <= '0;
    else if (sw_clr) timeout_q <= sat_inc(timeout_q);
  assign stat_timeout = timeout_q;
`else
  assign sw_ptr = '0;
  assign sw_clr = 1'b0;
  assign stat_timeout = '0;
`endif
  always_comb begin
    valid_d = valid_q;
    if (end_hit) valid_d[end_tag] = 1'b0;
    if (sw_clr) valid_d[sw_ptr] = 1'b0;
    if (st) valid_d[start_tag] = 1'b1;
    if (cfg_clear) valid_d = '0;
  end
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < DEPTH; i++) pending_d = pending_d + (TAG_WIDTH+1)'(valid_d[i]);
  end
  always_ff @(posedge clk)
    if (st) ts_q[start_tag] <= timestamp;
  always_ff @(posedge clk)
    if (rst || cfg_clear) begin
      valid_q <= '0;
      pending_q <= '0;
      lat_valid_q <= 1'b0;
      lat_start_q <= '0;
      lat_end_q <= '0;
      orphan_q <= '0;
      dup_q <= '0;
    end else begin
      valid_q <= valid_d;
      pending_q <= pending_d;
      lat_valid_q <= end_hit;
      if (end_hit) lat_start_q <= ts_q[end_tag];
      if (end_hit) lat_end_q <= timestamp;
      if (orphan) orphan_q <= sat_inc(orphan_q);
      if (dup) dup_q <= sat_inc(dup_q);
    end
  assign latency_start = lat_start_q;
  assign latency_end = lat_end_q;
  assign latency_valid = lat_valid_q;
  assign pending_count = pending_q;
  assign stat_orphan_end = orphan_q;
  assign stat_dup_start = dup_q;
endmodule

// File: tb/tb_latency_tag_tracker.sv
// tb_latency_tag_tracker: directed-vector self-checking bench for latency_tag_tracker.
module tb_latency_tag_tracker;
  logic clk = 1'b0;
  logic rst, cfg_enable, cfg_clear, start_valid, end_valid;
  logic [63:0] timestamp;
  logic [5:0] start_tag, end_tag;
  logic [63:0] latency_start, latency_end;
  logic latency_valid;
  logic [6:0] pending_count;
  logic [31:0] stat_orphan_end, stat_dup_start, stat_timeout;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  latency_tag_tracker #(.TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst(rst), .timestamp(timestamp), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
    .start_valid(start_valid), .start_tag(start_tag), .end_valid(end_valid), .end_tag(end_tag),
    .latency_start(latency_start), .latency_end(latency_end), .latency_valid(latency_valid),
    .pending_count(pending_count), .stat_orphan_end(stat_orphan_end),
    .stat_dup_start(stat_dup_start), .stat_timeout(stat_timeout)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ev(input logic sv, input logic [5:0] stg, input logic ev_, input logic [5:0] etg, input logic [63:0] ts);
    start_valid = sv;
    start_tag = stg;
    end_valid = ev_;
    end_tag = etg;
    timestamp = ts;
    tick();
    start_valid = 1'b0;
    end_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; cfg_enable = 1'b1; cfg_clear = 1'b0; start_valid = 1'b0; end_valid = 1'b0;
    start_tag = '0; end_tag = '0; timestamp = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pending", 64'(pending_count), 0);
    chk("rst_lat_valid", 64'(latency_valid), 0);
    chk("rst_lat_start", latency_start, 0);
    chk("rst_orphan", 64'(stat_orphan_end), 0);
    chk("rst_dup", 64'(stat_dup_start), 0);
    chk("rst_timeout", 64'(stat_timeout), 0);
    ev(1, 5, 0, 0, 100);
    chk("match_pend1", 64'(pending_count), 1);
    chk("match_idle_valid", 64'(latency_valid), 0);
    ev(0, 0, 1, 5, 137);
    chk("match_valid", 64'(latency_valid), 1);
    chk("match_start", latency_start, 100);
    chk("match_end", latency_end, 137);
    chk("match_pend0", 64'(pending_count), 0);
    ev(0, 0, 0, 0, 140);
    chk("strobe_one_cycle", 64'(latency_valid), 0);
    chk("hold_start", latency_start, 100);
    ev(0, 0, 1, 9, 150);
    chk("orphan_no_strobe", 64'(latency_valid), 0);
    chk("orphan_cnt", 64'(stat_orphan_end), 1);
    ev(1, 3, 0, 0, 10);
    ev(1, 3, 0, 0, 20);
    chk("dup_cnt", 64'(stat_dup_start), 1);
    chk("dup_pend", 64'(pending_count), 1);
    ev(0, 0, 1, 3, 25);
    chk("dup_lat_start", latency_start, 20);
    chk("dup_lat_end", latency_end, 25);
    ev(1, 7, 0, 0, 50);
    ev(1, 7, 1, 7, 80);
    chk("same_valid", 64'(latency_valid), 1);
    chk("same_start", latency_start, 50);
    chk("same_end", latency_end, 80);
    chk("same_pend", 64'(pending_count), 1);
    chk("same_no_dup", 64'(stat_dup_start), 1);
    ev(0, 0, 1, 7, 90);
    chk("same_rewritten", latency_start, 80);
    chk("same_pend0", 64'(pending_count), 0);
    ev(1, 12, 0, 0, 300);
    ev(1, 13, 1, 12, 320);
    chk("diff_start", latency_start, 300);
    chk("diff_pend", 64'(pending_count), 1);
    ev(0, 0, 1, 13, 330);
    chk("diff_second", latency_start, 320);
    chk("diff_pend0", 64'(pending_count), 0);
    ev(1, 4, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    ev(0, 0, 1, 4, 4);
    chk("wrap_start", latency_start, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("wrap_end", latency_end, 4);
    for (int i = 20; i < 24; i++) ev(1, 6'(i), 0, 0, 64'(i));
    chk("clr_pend4", 64'(pending_count), 4);
    cfg_clear = 1'b1;
    ev(1, 24, 1, 20, 30);
    cfg_clear = 1'b0;
    chk("clr_pend", 64'(pending_count), 0);
    chk("clr_orphan", 64'(stat_orphan_end), 0);
    chk("clr_dup", 64'(stat_dup_start), 0);
    chk("clr_lat_valid", 64'(latency_valid), 0);
    chk("clr_lat_start", latency_start, 0);
    cfg_enable = 1'b0;
    ev(1, 1, 0, 0, 40);
    chk("dis_pend", 64'(pending_count), 0);
    cfg_enable = 1'b1;
    ev(0, 0, 1, 1, 41);
    chk("dis_orphan", 64'(stat_orphan_end), 1);
    chk("dis_no_strobe", 64'(latency_valid), 0);
`ifdef LAT_TRACK_TIMEOUT_EN
    begin
      int t;
      ev(1, 2, 0, 0, 0);
      chk("to_pend1", 64'(pending_count), 1);
      t = 1;
      while (stat_timeout == 0 && t < 256 + 64 + 8) begin
        ev(0, 0, 0, 0, 64'(t));
        t++;
      end
      chk("to_cnt", 64'(stat_timeout), 1);
      chk("to_pend0", 64'(pending_count), 0);
      chk("to_not_early", 64'(t >= 256), 1);
      ev(0, 0, 1, 2, 64'(t));
      chk("to_orphan", 64'(stat_orphan_end), 2);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
